// File: rtl/wb_stage.sv
// Writeback stage: registers the EX instruction and result, aligns load data and drives the regfile write port.
// Latency: one cycle from EX to WB; wrt_* and stall_ex are combinational from WB state and dmem_rvalid.
// Backpressure: stall_ex holds EX/IF and freezes WB while a load response is outstanding, up to LOAD_TIMEOUT cycles.
//
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   ex_valid, ex_flush   EX instruction valid / squash (flush captures NOP_INST)
//   ex_inst, ex_pc       EX instruction word and its PC
//   ex_alu, ex_rs1       ALU result (address or value) and forwarded rs1 (CSR source)
//   dmem_rdata/rvalid    load data word and its valid strobe
//   inst_WB, wrt_addr    instruction in WB and its destination (0 if no write), for the hazard unit
//   wrt_data, wrt_en     regfile write data / forwarding value and write strobe
//   stall_ex             hold EX and IF this cycle
//   load_err             sticky load-timeout flag
//   csr_tohost           tohost CSR, present only when WB_CSR_EN is defined
module wb_stage #(
  parameter int unsigned LOAD_TIMEOUT = 16,
  parameter logic [31:0] NOP_INST     = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        ex_flush,
  input  logic [31:0] ex_inst,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_alu,
  input  logic [31:0] ex_rs1,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_rvalid,
  output logic [31:0] inst_WB,
  output logic [4:0]  wrt_addr,
  output logic [31:0] wrt_data,
  output logic        wrt_en,
  output logic        stall_ex,
  output logic        load_err
`ifdef WB_CSR_EN
  ,
  output logic [31:0] csr_tohost
`endif
);

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [7:0] TIMEOUT    = 8'(LOAD_TIMEOUT);
`ifdef WB_CSR_EN
  localparam logic [6:0]  OPC_CSR    = 7'b1110011;
  localparam logic [2:0]  FNC_RW     = 3'b001;
  localparam logic [11:0] CSR_TOHOST = 12'h51E;
`endif

  typedef enum logic {S_RUN, S_WAIT} state_t;

  typedef struct packed {
    logic        vld;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] alu;
  } wb_reg_t;

  wb_reg_t     wb_q;
  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        set_err;
  logic        is_load;
  logic        ex_live;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [1:0]  off;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign ex_live = ex_valid && !ex_flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_q     <= '{vld: 1'b0, inst: NOP_INST, pc: 32'd0, alu: 32'd0};
      state    <= S_RUN;
      cnt      <= 8'd0;
      load_err <= 1'b0;
`ifdef WB_CSR_EN
      csr_tohost <= 32'd0;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (set_err) load_err <= 1'b1;
      // A stall freezes WB, so a flush arriving while stalled has no effect;
      // EX re-presents its instruction once the stall drops.
      if (!stall_ex) begin
        wb_q.vld  <= ex_live;
        wb_q.inst <= ex_live ? ex_inst : NOP_INST;
        wb_q.pc   <= ex_pc;
        wb_q.alu  <= ex_alu;
`ifdef WB_CSR_EN
        // tohost is written as the CSR instruction enters WB, never via rd.
        if (ex_live && ex_inst[6:0] == OPC_CSR && ex_inst[14:12] == FNC_RW &&
            ex_inst[31:20] == CSR_TOHOST)
          csr_tohost <= ex_rs1;
`endif
      end
    end
  end

`ifndef WB_CSR_EN
  logic unused_rs1;
  assign unused_rs1 = ^ex_rs1;
`endif

  assign inst_WB = wb_q.inst;
  assign opcode  = wb_q.inst[6:0];
  assign funct3  = wb_q.inst[14:12];
  assign is_load = wb_q.vld && (opcode == OPC_LOAD);

  always_comb begin
    wrt_addr = 5'd0;
    case (opcode)
      OPC_R, OPC_I, OPC_LOAD, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR:
        wrt_addr = wb_q.inst[11:7];
      default: wrt_addr = 5'd0;
    endcase
  end

  // Byte lane from the full offset, half lane from offset bit 1 only.
  assign off     = wb_q.alu[1:0];
  assign ld_byte = dmem_rdata[{off, 3'b000} +: 8];
  assign ld_half = dmem_rdata[{off[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = dmem_rdata;
    case (funct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_comb begin
    wrt_data = wb_q.alu;
    case (opcode)
      OPC_JAL, OPC_JALR: wrt_data = wb_q.pc + 32'd4;
      OPC_LOAD:          wrt_data = ld_data;
      default:           wrt_data = wb_q.alu;
    endcase
  end

  // A load writes only in the cycle its data arrives; a timed-out load never writes.
  assign wrt_en = wb_q.vld && (wrt_addr != 5'd0) && (!is_load || dmem_rvalid);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_ex  = 1'b0;
    set_err   = 1'b0;
    case (state)
      S_RUN: begin
        if (is_load && !dmem_rvalid) begin
          stall_ex  = 1'b1;
          cnt_nxt   = 8'd1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dmem_rvalid) begin
          cnt_nxt   = 8'd0;
          state_nxt = S_RUN;
        end else if (cnt == TIMEOUT) begin
          set_err   = 1'b1;
          cnt_nxt   = 8'd0;
          state_nxt = S_RUN;
        end else begin
          cnt_nxt  = cnt + 8'd1;
          stall_ex = 1'b1;
        end
      end
      default: state_nxt = S_RUN;
    endcase
  end

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] ADDI_X5  = 32'h0070_0293;
  localparam logic [31:0] SW       = 32'h0011_2223;
  localparam logic [31:0] LB_X6    = 32'h0000_0303;
  localparam logic [31:0] LBU_X6   = 32'h0000_4303;
  localparam logic [31:0] LH_X8    = 32'h0000_1403;
  localparam logic [31:0] LHU_X8   = 32'h0000_5403;
  localparam logic [31:0] LW_X7    = 32'h0000_2383;
  localparam logic [31:0] ADDI_X9  = 32'h0550_0493;
  localparam logic [31:0] ADDI_X10 = 32'h0010_0513;
  localparam logic [31:0] JAL_X1   = 32'h0000_00EF;
  localparam logic [31:0] JALR_X1  = 32'h0000_00E7;
  localparam logic [31:0] LUI_X11  = 32'h1234_55B7;
  localparam logic [31:0] BEQ      = 32'h0000_0463;
  localparam logic [31:0] CSR_TH   = 32'h51E0_91F3;
  localparam logic [31:0] CSR_OTH  = 32'h51F2_91F3;

  logic        clk;
  logic        reset;
  logic        ex_valid;
  logic        ex_flush;
  logic [31:0] ex_inst;
  logic [31:0] ex_pc;
  logic [31:0] ex_alu;
  logic [31:0] ex_rs1;
  logic [31:0] dmem_rdata;
  logic        dmem_rvalid;
  logic [31:0] inst_WB;
  logic [4:0]  wrt_addr;
  logic [31:0] wrt_data;
  logic        wrt_en;
  logic        stall_ex;
  logic        load_err;
`ifdef WB_CSR_EN
  logic [31:0] csr_tohost;
`endif

  wb_stage dut (
    .clk         (clk),
    .reset       (reset),
    .ex_valid    (ex_valid),
    .ex_flush    (ex_flush),
    .ex_inst     (ex_inst),
    .ex_pc       (ex_pc),
    .ex_alu      (ex_alu),
    .ex_rs1      (ex_rs1),
    .dmem_rdata  (dmem_rdata),
    .dmem_rvalid (dmem_rvalid),
    .inst_WB     (inst_WB),
    .wrt_addr    (wrt_addr),
    .wrt_data    (wrt_data),
    .wrt_en      (wrt_en),
    .stall_ex    (stall_ex),
    .load_err    (load_err)
`ifdef WB_CSR_EN
    ,
    .csr_tohost  (csr_tohost)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        en;
    logic        stall;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   stall_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_wb(input logic [4:0] a, input logic [31:0] d, input logic e, input logic s);
    exp_t x;
    x.addr  = a;
    x.data  = d;
    x.en    = e;
    x.stall = s;
    sb_q.push_back(x);
  endtask

  task automatic check_wb(input string tag);
    exp_t x;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end else begin
      x = sb_q.pop_front();
      chk({tag, ".addr"}, {27'd0, wrt_addr}, {27'd0, x.addr});
      chk({tag, ".en"}, {31'd0, wrt_en}, {31'd0, x.en});
      chk({tag, ".stall"}, {31'd0, stall_ex}, {31'd0, x.stall});
      if (x.en) chk({tag, ".data"}, wrt_data, x.data);
    end
  endtask

  task automatic ex_drive(input logic v, input logic [31:0] i, input logic [31:0] p,
                          input logic [31:0] a, input logic [31:0] r, input logic f);
    ex_valid = v;
    ex_inst  = i;
    ex_pc    = p;
    ex_alu   = a;
    ex_rs1   = r;
    ex_flush = f;
  endtask

  task automatic mem_drive(input logic [31:0] d, input logic v);
    dmem_rdata  = d;
    dmem_rvalid = v;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1;
    ex_drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    mem_drive(32'd0, 1'b0);
    cycle();
    cycle();
    settle();
    chk("rst.inst", inst_WB, NOP);
    chk("rst.addr", {27'd0, wrt_addr}, 32'd0);
    chk("rst.data", wrt_data, 32'd0);
    chk("rst.en", {31'd0, wrt_en}, 32'd0);
    chk("rst.stall", {31'd0, stall_ex}, 32'd0);
    chk("rst.err", {31'd0, load_err}, 32'd0);
`ifdef WB_CSR_EN
    chk("rst.tohost", csr_tohost, 32'd0);
`endif
    reset = 1'b0;

    // Reset while waiting on a load
    ex_drive(1'b1, LW_X7, 32'h100, 32'h300, 32'd0, 1'b0);
    cycle();
    ex_drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    settle();
    chk("wait.stall", {31'd0, stall_ex}, 32'd1);
    cycle();
    reset = 1'b1;
    cycle();
    cycle();
    settle();
    chk("rstwait.inst", inst_WB, NOP);
    chk("rstwait.en", {31'd0, wrt_en}, 32'd0);
    chk("rstwait.stall", {31'd0, stall_ex}, 32'd0);
    chk("rstwait.err", {31'd0, load_err}, 32'd0);
    reset = 1'b0;

    // ALU op then store
    ex_drive(1'b1, ADDI_X5, 32'h100, 32'd7, 32'd0, 1'b0);
    cycle();
    ex_drive(1'b1, SW, 32'h104, 32'h40, 32'd0, 1'b0);
    settle();
    expect_wb(5'd5, 32'd7, 1'b1, 1'b0);
    check_wb("addi");
    chk("addi.inst", inst_WB, ADDI_X5);
    cycle();
    ex_drive(1'b1, LB_X6, 32'h108, 32'h202, 32'd0, 1'b0);
    settle();
    expect_wb(5'd0, 32'h40, 1'b0, 1'b0);
    check_wb("sw");

    // Sub-word loads returning in the same cycle
    cycle();
    mem_drive(32'h0080_0000, 1'b1);
    ex_drive(1'b1, LBU_X6, 32'h10C, 32'h202, 32'd0, 1'b0);
    settle();
    expect_wb(5'd6, 32'hFFFF_FF80, 1'b1, 1'b0);
    check_wb("lb");
    cycle();
    ex_drive(1'b1, LH_X8, 32'h110, 32'h13, 32'd0, 1'b0);
    settle();
    expect_wb(5'd6, 32'h0000_0080, 1'b1, 1'b0);
    check_wb("lbu");
    cycle();
    mem_drive(32'h8001_F234, 1'b1);
    ex_drive(1'b1, LHU_X8, 32'h114, 32'h10, 32'd0, 1'b0);
    settle();
    expect_wb(5'd8, 32'hFFFF_8001, 1'b1, 1'b0);
    check_wb("lh");
    cycle();
    ex_drive(1'b1, LW_X7, 32'h118, 32'h300, 32'd0, 1'b0);
    settle();
    expect_wb(5'd8, 32'h0000_F234, 1'b1, 1'b0);
    check_wb("lhu");

    // Word load with data three cycles late; a flush during the stall is ignored
    cycle();
    mem_drive(32'd0, 1'b0);
    ex_drive(1'b1, ADDI_X9, 32'h11C, 32'h55, 32'd0, 1'b0);
    settle();
    expect_wb(5'd7, 32'd0, 1'b0, 1'b1);
    check_wb("lw.s0");
    cycle();
    ex_flush = 1'b1;
    settle();
    expect_wb(5'd7, 32'd0, 1'b0, 1'b1);
    check_wb("lw.s1");
    cycle();
    ex_flush = 1'b0;
    settle();
    expect_wb(5'd7, 32'd0, 1'b0, 1'b1);
    check_wb("lw.s2");
    cycle();
    mem_drive(32'hDEAD_BEEF, 1'b1);
    settle();
    expect_wb(5'd7, 32'hDEAD_BEEF, 1'b1, 1'b0);
    check_wb("lw.done");
    cycle();
    mem_drive(32'd0, 1'b0);
    ex_drive(1'b1, LW_X7, 32'h120, 32'h400, 32'd0, 1'b0);
    settle();
    expect_wb(5'd9, 32'h55, 1'b1, 1'b0);
    check_wb("resume");
    chk("resume.inst", inst_WB, ADDI_X9);

    // Load timeout
    cycle();
    ex_drive(1'b1, ADDI_X10, 32'h124, 32'd1, 32'd0, 1'b0);
    stall_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (i != 0) cycle();
      settle();
      if (stall_ex) stall_cnt++;
      expect_wb(5'd7, 32'd0, 1'b0, 1'b1);
      check_wb("tmo.wait");
    end
    cycle();
    settle();
    expect_wb(5'd7, 32'd0, 1'b0, 1'b0);
    check_wb("tmo.end");
    chk("tmo.stallcnt", stall_cnt, 32'd16);
    chk("tmo.err_pre", {31'd0, load_err}, 32'd0);
    cycle();
    mem_drive(32'hAAAA_5555, 1'b1);
    ex_drive(1'b1, ADDI_X5, 32'h128, 32'd7, 32'd0, 1'b1);
    settle();
    expect_wb(5'd10, 32'd1, 1'b1, 1'b0);
    check_wb("after_tmo");
    chk("tmo.err", {31'd0, load_err}, 32'd1);

    // Flush inserts a NOP
    cycle();
    mem_drive(32'd0, 1'b0);
    ex_drive(1'b1, JAL_X1, 32'hFFFF_FFFC, 32'h123, 32'd0, 1'b0);
    settle();
    chk("flush.inst", inst_WB, NOP);
    expect_wb(5'd0, 32'd7, 1'b0, 1'b0);
    check_wb("flush");

    // Link address wraps; JALR, LUI, branch
    cycle();
    ex_drive(1'b1, JALR_X1, 32'h200, 32'h300, 32'd0, 1'b0);
    settle();
    expect_wb(5'd1, 32'd0, 1'b1, 1'b0);
    check_wb("jal_wrap");
    cycle();
    ex_drive(1'b1, LUI_X11, 32'h204, 32'h1234_5000, 32'd0, 1'b0);
    settle();
    expect_wb(5'd1, 32'h204, 1'b1, 1'b0);
    check_wb("jalr");
    cycle();
    ex_drive(1'b1, BEQ, 32'h208, 32'h1, 32'd0, 1'b0);
    settle();
    expect_wb(5'd11, 32'h1234_5000, 1'b1, 1'b0);
    check_wb("lui");
    cycle();
    ex_drive(1'b1, CSR_TH, 32'h20C, 32'h0, 32'd1, 1'b0);
    settle();
    expect_wb(5'd0, 32'h1, 1'b0, 1'b0);
    check_wb("beq");

    // CSR writes to tohost never write rd
    cycle();
    ex_drive(1'b1, CSR_OTH, 32'h210, 32'h0, 32'd5, 1'b0);
    settle();
    expect_wb(5'd0, 32'h0, 1'b0, 1'b0);
    check_wb("csr_th");
`ifdef WB_CSR_EN
    chk("tohost.wr", csr_tohost, 32'd1);
`endif
    cycle();
    ex_drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    settle();
    expect_wb(5'd0, 32'h0, 1'b0, 1'b0);
    check_wb("csr_oth");
`ifdef WB_CSR_EN
    chk("tohost.hold", csr_tohost, 32'd1);
`endif
    cycle();
    settle();
    chk("bubble.inst", inst_WB, NOP);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
